mdu_multicycle: RTL and testbench

- Parametrised multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
- Successor of the fixed 32-bit MDU: configurable operand width and per-class latency.
- Adds multiply-accumulate/subtract (madd/maddu/msub/msubu) and an in-flight abort input for pipeline flushes.
- Owns the HI/LO registers. The hazard unit stalls MDU-dependent instructions in D while busy is high.

---
 rtl/mdu_multicycle.sv | 119 +++++++++++
 tb/tb_mdu_multicycle.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_multicycle.sv
// mdu_multicycle: multi-cycle multiply/divide/accumulate unit owning HI/LO.
// Operands are latched at start; the result commits N edges later unless flushed.
module mdu_multicycle #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               is_mul, is_div, sgn, is_div_q, a_neg, b_neg;
    logic [2*WIDTH-1:0] ax, bx, prod, mres;
    logic [WIDTH-1:0]   ua, ub, ubs, uq, ur, dq, dr;

    assign is_mul = op inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8};
    assign is_div = op inside {4'd3, 4'd4};
    assign busy   = state_q == RUN;
    assign start  = (is_mul || is_div) && !busy && !flush;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Signed forms sign-extend to 2*WIDTH so one unsigned multiply serves both.
    assign sgn      = op_q inside {4'd1, 4'd3, 4'd5, 4'd7};
    assign is_div_q = op_q inside {4'd3, 4'd4};
    assign ax       = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    assign bx       = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    assign prod     = ax * bx;
    assign mres     = (op_q inside {4'd5, 4'd6}) ? acc_q + prod :
                      (op_q inside {4'd7, 4'd8}) ? acc_q - prod : prod;

    // Divide on magnitudes, then restore signs; MIN/-1 wraps back to MIN naturally.
    assign a_neg = sgn & a_q[WIDTH-1];
    assign b_neg = sgn & b_q[WIDTH-1];
    assign ua    = a_neg ? -a_q : a_q;
    assign ub    = b_neg ? -b_q : b_q;
    assign ubs   = (ub == '0) ? WIDTH'(1) : ub;
    assign uq    = ua / ubs;
    assign ur    = ua % ubs;
    assign dq    = (a_neg ^ b_neg) ? -uq : uq;
    assign dr    = a_neg ? -ur : ur;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (busy) begin
            cnt_d = cnt_q - CW'(1);
            if (flush) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!is_div_q) begin
                    {hi_d, lo_d} = mres;
                end else if (b_q != '0) begin
                    hi_d = dr;
                    lo_d = dq;
                end
            end
        end else if (start) begin
            state_d = RUN;
            cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            op_d    = op;
            a_d     = rs_val;
            b_d     = rt_val;
            acc_d   = {hi_q, lo_q};
        end else if (!flush) begin
            hi_d = (op == 4'd9) ? rs_val : hi_q;
            lo_d = (op == 4'd10) ? rs_val : lo_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_mdu_multicycle.sv
// tb_mdu_multicycle: directed table, hand-written corner sequences and a
// randomized run against an arithmetic reference model of HI/LO.
module tb_mdu_multicycle;
    logic        clk = 0, reset = 1, flush = 0;
    logic [3:0]  op = 0;
    logic [31:0] rs_val = 0, rt_val = 0;
    logic        start, busy;
    logic [31:0] hi, lo;

    int          nvec = 0, nerr = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs, rt, pre_hi, pre_lo, exp_hi, exp_lo;
    } vec_t;
    vec_t tbl[12];

    mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .flush(flush), .start(start), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hl(input logic [31:0] hv, input logic [31:0] lv);
        op = 4'd9; rs_val = hv; tick();
        op = 4'd10; rs_val = lv; tick();
        op = 4'd0;
        m_hi = hv; m_lo = lv;
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int cyc,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        op = o; rs_val = a; rt_val = b;
        #1;
        chk({name, " start"}, start, 1);
        tick();
        op = 4'd0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk({name, " cycles"}, n, cyc);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
    endtask

    function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
        logic [63:0] acc, sp, up;
        int q, r;
        acc = {h, l};
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'b0, a} * {32'b0, b};
        case (o)
            4'd1: return sp;
            4'd2: return up;
            4'd5: return acc + sp;
            4'd6: return acc + up;
            4'd7: return acc - sp;
            4'd8: return acc - up;
            4'd3: begin
                if (b == 0) return acc;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            4'd4: return (b == 0) ? acc : {a % b, a / b};
            default: return acc;
        endcase
    endfunction

    initial begin
        int n;
        logic [3:0] o;
        logic [31:0] a, b;
        logic [63:0] e;

        tbl[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  32'h00000002, 32'hFFFFFFFA};
        tbl[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,  32'h0,  32'h00000000, 32'h80000000};
        tbl[4]  = '{4'd3, 32'h00001234, 32'h0,        32'h11, 32'h22, 32'h00000011, 32'h00000022};
        tbl[5]  = '{4'd6, 32'd3,        32'd5,        32'h0,  32'h10, 32'h00000000, 32'h0000001F};
        tbl[6]  = '{4'd7, 32'd0,        32'h1234,     32'h0,  32'h1F, 32'h00000000, 32'h0000001F};
        tbl[7]  = '{4'd7, 32'd1,        32'h20,       32'h0,  32'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[8]  = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'h00000001, 32'h7FFFFFFC};
        tbl[9]  = '{4'd5, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h5,  32'h00000000, 32'h00000003};
        tbl[10] = '{4'd8, 32'd1,        32'd1,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[11] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFD};

        #12 reset = 0;
        tick();
        chk("reset busy", busy, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);

        foreach (tbl[i]) begin
            set_hl(tbl[i].pre_hi, tbl[i].pre_lo);
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt,
                   (tbl[i].op inside {4'd3, 4'd4}) ? 10 : 5, tbl[i].exp_hi, tbl[i].exp_lo);
        end

        // chained madd uses the just-committed product
        set_hl(32'h0, 32'h0);
        run_op("chain mult", 4'd1, 32'd6, 32'd7, 5, 32'h0, 32'd42);
        run_op("chain madd", 4'd5, 32'd2, 32'd3, 5, 32'h0, 32'd48);

        for (int k = 1; k <= 5; k++) begin
            set_hl(32'hA, 32'hB);
            op = 4'd1; rs_val = 3; rt_val = 4;
            tick();
            op = 4'd0;
            repeat (k - 1) tick();
            chk($sformatf("flush%0d pre busy", k), busy, 1);
            flush = 1;
            tick();
            flush = 0;
            chk($sformatf("flush%0d busy", k), busy, 0);
            chk($sformatf("flush%0d hi", k), hi, 32'hA);
            chk($sformatf("flush%0d lo", k), lo, 32'hB);
            repeat (6) tick();
            chk($sformatf("flush%0d late lo", k), lo, 32'hB);
        end

        op = 4'd9; rs_val = 32'h55; flush = 1;
        #1;
        chk("flush mthi start", start, 0);
        op = 4'd1;
        #1;
        chk("flush mult start", start, 0);
        op = 4'd9;
        tick();
        op = 4'd0; flush = 0;
        chk("flush mthi hi", hi, 32'hA);
        chk("flush mult busy", busy, 0);

        set_hl(32'h0, 32'h0);
        op = 4'd1; rs_val = 2; rt_val = 3;
        tick();
        op = 4'd1; rs_val = 7; rt_val = 7;
        #1;
        chk("busy op start", start, 0);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (n >= 3) op = 4'd0;
        end
        chk("busy op cycles", n, 5);
        chk("busy op hi", hi, 0);
        chk("busy op lo", lo, 6);
        tick();
        chk("busy op no restart", busy, 0);

        set_hl(32'h5, 32'h6);
        op = 4'd1; rs_val = 3; rt_val = 4;
        tick();
        op = 4'd0;
        tick();
        #2 reset = 1;
        #1;
        chk("async reset busy", busy, 0);
        chk("async reset hi", hi, 0);
        chk("async reset lo", lo, 0);
        #1 reset = 0;
        repeat (8) tick();
        chk("post reset busy", busy, 0);
        chk("post reset hi", hi, 0);
        chk("post reset lo", lo, 0);
        m_hi = 0; m_lo = 0;

        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 12));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if (o >= 4'd1 && o <= 4'd8) begin
                e = ref_op(o, a, b, m_hi, m_lo);
                run_op($sformatf("rnd%0d op%0d", i, o), o, a, b,
                       (o inside {4'd3, 4'd4}) ? 10 : 5, e[63:32], e[31:0]);
                m_hi = e[63:32]; m_lo = e[31:0];
            end else begin
                op = o; rs_val = a;
                tick();
                op = 4'd0;
                if (o == 4'd9) m_hi = a;
                if (o == 4'd10) m_lo = a;
                chk($sformatf("rnd%0d op%0d busy", i, o), busy, 0);
                chk($sformatf("rnd%0d op%0d hilo", i, o), {hi, lo}, {m_hi, m_lo});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
